asg_lin: RTL

// - Linear output stage directly downstream of the arbitrary signal generator channel; consumes its sample stream.
// - Applies per-channel gain and offset, saturates to DAC range, forwards the stream to the DAC interface.
// - 2-stage pipeline with full AXI4-stream backpressure; counts saturated samples for software.

---
 rtl/asg_pkg.sv | 35 +++
 rtl/asg_lin.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/asg_pkg.sv
// Shared constants and the saturation helper for the ASG linear output stage.
package asg_pkg;

    localparam int unsigned DWM_DEF = 16;
    localparam int unsigned DWO_DEF = 14;
    localparam int unsigned SAT_W   = 64;

    localparam logic signed [DWM_DEF-1:0] UNITY_GAIN = DWM_DEF'(1) <<< (DWM_DEF - 2);

    typedef struct packed {
        logic                    clip;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Clamp a signed value into the signed range of 'width' bits and report clipping.
    function automatic sat_t sat(input logic signed [SAT_W-1:0] value,
                                 input int unsigned             width);
        sat_t                    r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi     = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (width - 1));
        r.clip = 1'b0;
        r.val  = value;
        if (value > hi) begin
            r.clip = 1'b1;
            r.val  = hi;
        end else if (value < lo) begin
            r.clip = 1'b1;
            r.val  = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/asg_lin.sv
// Gain/offset/saturate stage between the signal generator and the DAC;
// two pipeline registers with AXI4-stream backpressure and a clip counter.
module asg_lin
    import asg_pkg::*;
#(
    parameter int unsigned DWI = 14,
    parameter int unsigned DWO = DWO_DEF,
    parameter int unsigned DWM = DWM_DEF,
    parameter int unsigned DWS = 14,
    parameter int unsigned DWC = 16
) (
    input  logic                   sti_aclk,
    input  logic                   sti_aresetn,
    input  logic [DWI-1:0]         sti_tdata,
    input  logic [(DWI+7)/8-1:0]   sti_tkeep,
    input  logic                   sti_tlast,
    input  logic                   sti_tvalid,
    output logic                   sti_tready,
    output logic [DWO-1:0]         sto_tdata,
    output logic [(DWO+7)/8-1:0]   sto_tkeep,
    output logic                   sto_tlast,
    output logic                   sto_tvalid,
    input  logic                   sto_tready,
    input  logic                   ctl_rst,
    input  logic [DWM-1:0]         cfg_mul,
    input  logic [DWS-1:0]         cfg_sum,
    output logic [DWC-1:0]         sts_sat,
    output logic                   sts_act
);

    localparam int unsigned DWP = DWI + DWM;
    localparam int unsigned DWA = DWP + 1;

    logic                  rdy1;
    logic                  rdy2;

    logic                  vld1_q,  vld1_d;
    logic                  last1_q, last1_d;
    logic signed [DWP-1:0] mul_q,   mul_d;
    logic signed [DWS-1:0] add_q,   add_d;

    logic                  vld2_q,  vld2_d;
    logic                  last2_q, last2_d;
    logic                  clip2_q, clip2_d;
    logic [DWO-1:0]        dat2_q,  dat2_d;
    logic [DWC-1:0]        sat_cnt_q, sat_cnt_d;

    logic signed [DWA-1:0]   sum;
    sat_t                    sat_res;
    logic signed [SAT_W-1:0] sat_val;
    logic                    unused_ok;

    assign rdy2       = ~vld2_q | sto_tready;
    assign rdy1       = ~vld1_q | rdy2;
    assign sti_tready = rdy1;

    // Stage 1: multiply, and latch the offset alongside so config is per-sample.
    always_comb begin
        vld1_d  = vld1_q;
        last1_d = last1_q;
        mul_d   = mul_q;
        add_d   = add_q;
        if (rdy1) begin
            vld1_d = sti_tvalid;
            if (sti_tvalid) begin
                last1_d = sti_tlast;
                mul_d   = DWP'($signed(sti_tdata)) * DWP'($signed(cfg_mul));
                add_d   = $signed(cfg_sum);
            end
        end
        if (ctl_rst) begin
            vld1_d  = 1'b0;
            last1_d = 1'b0;
        end
    end

    always_comb begin
        sum     = DWA'(mul_q >>> (DWM - 2)) + DWA'(add_q);
        sat_res = sat(SAT_W'(sum), DWO);
        sat_val = sat_res.val;
    end

    // Stage 2: data holds its last value when no new sample arrives.
    always_comb begin
        vld2_d  = vld2_q;
        last2_d = last2_q;
        clip2_d = clip2_q;
        dat2_d  = dat2_q;
        if (rdy2) begin
            vld2_d  = vld1_q;
            last2_d = vld1_q & last1_q;
            if (vld1_q) begin
                dat2_d  = sat_val[DWO-1:0];
                clip2_d = sat_res.clip;
            end else begin
                clip2_d = 1'b0;
            end
        end
        if (ctl_rst) begin
            vld2_d  = 1'b0;
            last2_d = 1'b0;
            clip2_d = 1'b0;
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (vld2_q && sto_tready && clip2_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
        if (ctl_rst) begin
            sat_cnt_d = '0;
        end
    end

    always_ff @(posedge sti_aclk or negedge sti_aresetn) begin
        if (!sti_aresetn) begin
            vld1_q    <= 1'b0;
            last1_q   <= 1'b0;
            mul_q     <= '0;
            add_q     <= '0;
            vld2_q    <= 1'b0;
            last2_q   <= 1'b0;
            clip2_q   <= 1'b0;
            dat2_q    <= '0;
            sat_cnt_q <= '0;
        end else begin
            vld1_q    <= vld1_d;
            last1_q   <= last1_d;
            mul_q     <= mul_d;
            add_q     <= add_d;
            vld2_q    <= vld2_d;
            last2_q   <= last2_d;
            clip2_q   <= clip2_d;
            dat2_q    <= dat2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sto_tdata  = dat2_q;
    assign sto_tkeep  = '1;
    assign sto_tlast  = last2_q;
    assign sto_tvalid = vld2_q;
    assign sts_sat    = sat_cnt_q;
    assign sts_act    = vld1_q | vld2_q;

    assign unused_ok = ^{sti_tkeep, sat_val[SAT_W-1:DWO]};

endmodule
